bus_matrix_wrr_arbiter: RTL

Weighted round-robin arbiter for one slave port of the bus matrix. It shares the slave between N_REQ masters, grants one master at a time, and lets each master move up to a configurable number of beats per turn. It never switches owner while a burst is locked by hold_i. It replaces the fixed-priority arbiter on slave ports that need fairness and bandwidth shaping.

---
 rtl/bus_matrix_wrr_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bus_matrix_wrr_arbiter.sv
// Purpose: weighted round-robin arbiter sharing one slave port between N_REQ masters; optional macro BUS_MATRIX_ARB_TIMEOUT_EN.
// Latency: registered one-hot grant, 1 cycle after req_i; re-arbitration on release with no idle gap.
// Backpressure: owner is held while hold_i=1; with BUS_MATRIX_ARB_TIMEOUT_EN, release is forced after TIMEOUT held cycles.
module bus_matrix_wrr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int CW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*CW-1:0]      weight_i,
  input  logic                     xfer_i,
  input  logic                     hold_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     gnt_valid_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || CW < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_matrix_wrr_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     credit_dec;
  logic [CW-1:0]     sel_weight;
  logic [CW-1:0]     fresh_credit;
  logic [IW-1:0]     owner_inc;
  logic [IW-1:0]     base;
  logic [IW-1:0]     sel;
  logic [IW:0]       idx;
  logic              any_req;
  logic              release_c;
  logic              force_rel;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(N_REQ-1)) return '0;
    return v + IW'(1);
  endfunction

  assign any_req   = |req_i;
  assign owner_inc = wrap_inc(owner_q);
  // In GRANT the search starts after the current owner so it is considered last.
  assign base      = (state_q == GRANT) ? owner_inc : ptr_q;

  // Circular priority search: first requester at or after base
  always_comb begin
    sel = base;
    idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = {1'b0, base} + (IW+1)'(i);
      if (idx >= (IW+1)'(N_REQ)) idx = idx - (IW+1)'(N_REQ);
      if (req_i[idx[IW-1:0]]) sel = idx[IW-1:0];
    end
  end

  assign sel_weight   = weight_i[int'(sel)*CW +: CW];
  assign fresh_credit = (sel_weight == '0) ? CW'(1) : sel_weight;
  assign credit_dec   = (xfer_i && credit_q != '0) ? credit_q - CW'(1) : credit_q;

`ifdef BUS_MATRIX_ARB_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT+1);
  logic [HW-1:0] hold_cnt_q;
  logic          timeout_q;

  // This held cycle is the TIMEOUT-th one in a row: release regardless of hold_i
  assign force_rel = (state_q == GRANT) && hold_i && (hold_cnt_q == HW'(TIMEOUT-1));

  // Count consecutive held grant cycles; clear on hold drop, release or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (state_q != GRANT || !hold_i || release_c) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + HW'(1);
    end
  end

  // Timeout pulse lands on the same edge as the forced grant change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= force_rel;
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state: grant from IDLE, spend credit in GRANT, release and re-arbitrate
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    credit_d  = credit_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          owner_d  = sel;
          gnt_d    = N_REQ'(1) << sel;
          credit_d = fresh_credit;
        end
      end
      GRANT: begin
        credit_d  = credit_dec;
        release_c = (!hold_i && (!req_i[owner_q] || credit_dec == '0)) || force_rel;
        if (release_c) begin
          ptr_d = owner_inc;
          if (any_req) begin
            owner_d  = sel;
            gnt_d    = N_REQ'(1) << sel;
            credit_d = fresh_credit;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign owner_o     = owner_q;
  assign gnt_valid_o = |gnt_q;

endmodule
